// File: rtl/serial_frame_loader_4_bit.sv
// serial_frame_loader_4_bit
// Assembles a framed serial bitstream into a DATA_WIDTH-bit word and presents
// it with a load strobe for a downstream parallel-in/parallel-out register.
// The word is held until Word_Ready_In; serial data arriving while a word is
// pending sets a sticky overrun flag.
//
// Optional feature: define SERIAL_FRAME_LOADER_PARITY_CHECK_EN to expect one
// even-parity bit after the data bits. On mismatch the word is dropped and
// Parity_Error_Out pulses for one cycle. Without the macro Parity_Error_Out
// is tied to 0 and the port list is unchanged.
//
// Ports:
//   Clk_In               clock, rising edge
//   Reset_In             synchronous active-high reset
//   Enable_In            1 = advance, 0 = freeze all state and outputs
//   Frame_Start_In       arm / restart a frame
//   Serial_Data_In       serial bit
//   Serial_Valid_In      qualifies Serial_Data_In
//   Word_Ready_In        downstream accepts the pending word
//   Parallel_Data_Out    last completed word
//   Load_Data_Signal_Out word pending (PIPO load)
//   Busy_Out             state != IDLE
//   Overrun_Error_Out    sticky overrun flag
//   Parity_Error_Out     one-cycle parity error pulse
module serial_frame_loader_4_bit #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Frame_Start_In,
  input  logic                  Serial_Data_In,
  input  logic                  Serial_Valid_In,
  input  logic                  Word_Ready_In,
  output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
  output logic                  Load_Data_Signal_Out,
  output logic                  Busy_Out,
  output logic                  Overrun_Error_Out,
  output logic                  Parity_Error_Out
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef SERIAL_FRAME_LOADER_PARITY_CHECK_EN
    PARITY = 2'd2,
`endif
    HOLD   = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next_c;

  // Shift register contents after capturing the current serial bit.
  always_comb begin
    shift_next_c = shift_reg;
    if (MSB_FIRST) begin
      shift_next_c = {shift_reg[DATA_WIDTH-2:0], Serial_Data_In};
    end else begin
      shift_next_c = {Serial_Data_In, shift_reg[DATA_WIDTH-1:1]};
    end
  end

`ifdef SERIAL_FRAME_LOADER_PARITY_CHECK_EN
  logic parity_err_q;
  assign Parity_Error_Out = parity_err_q;
`else
  assign Parity_Error_Out = 1'b0;
`endif

  // Frame state machine with registered outputs.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state                <= IDLE;
      bit_cnt              <= '0;
      shift_reg            <= '0;
      Parallel_Data_Out    <= '0;
      Load_Data_Signal_Out <= 1'b0;
      Busy_Out             <= 1'b0;
      Overrun_Error_Out    <= 1'b0;
`ifdef SERIAL_FRAME_LOADER_PARITY_CHECK_EN
      parity_err_q         <= 1'b0;
`endif
    end else if (Enable_In) begin
`ifdef SERIAL_FRAME_LOADER_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Frame_Start_In) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
            Busy_Out  <= 1'b1;
          end
        end

        SHIFT: begin
          // A restart wins over a coincident valid bit.
          if (Frame_Start_In) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else if (Serial_Valid_In) begin
            shift_reg <= shift_next_c;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_FRAME_LOADER_PARITY_CHECK_EN
              state <= PARITY;
`else
              state                <= HOLD;
              Parallel_Data_Out    <= shift_next_c;
              Load_Data_Signal_Out <= 1'b1;
`endif
            end
          end
        end

`ifdef SERIAL_FRAME_LOADER_PARITY_CHECK_EN
        PARITY: begin
          if (Frame_Start_In) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end else if (Serial_Valid_In) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            if ((^shift_reg) == Serial_Data_In) begin
              state                <= HOLD;
              Parallel_Data_Out    <= shift_reg;
              Load_Data_Signal_Out <= 1'b1;
            end else begin
              state        <= IDLE;
              Busy_Out     <= 1'b0;
              parity_err_q <= 1'b1;
            end
          end
        end
`endif

        HOLD: begin
          // Bits arriving while a word is pending are dropped.
          if (Serial_Valid_In) begin
            Overrun_Error_Out <= 1'b1;
          end
          if (Word_Ready_In) begin
            state                <= IDLE;
            Load_Data_Signal_Out <= 1'b0;
            Busy_Out             <= 1'b0;
          end
        end

        default: begin
          state                <= IDLE;
          Load_Data_Signal_Out <= 1'b0;
          Busy_Out             <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_loader_4_bit.sv
// Directed testbench for serial_frame_loader_4_bit (DATA_WIDTH=4, MSB_FIRST=1).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_serial_frame_loader_4_bit;

  logic       Clk_In = 1'b0;
  logic       Reset_In;
  logic       Enable_In;
  logic       Frame_Start_In;
  logic       Serial_Data_In;
  logic       Serial_Valid_In;
  logic       Word_Ready_In;
  logic [3:0] Parallel_Data_Out;
  logic       Load_Data_Signal_Out;
  logic       Busy_Out;
  logic       Overrun_Error_Out;
  logic       Parity_Error_Out;

  logic [3:0] pipo_q;
  int         n_checks = 0;
  int         n_errors = 0;

  serial_frame_loader_4_bit #(
    .DATA_WIDTH(4),
    .MSB_FIRST (1'b1)
  ) dut (
    .Clk_In              (Clk_In),
    .Reset_In            (Reset_In),
    .Enable_In           (Enable_In),
    .Frame_Start_In      (Frame_Start_In),
    .Serial_Data_In      (Serial_Data_In),
    .Serial_Valid_In     (Serial_Valid_In),
    .Word_Ready_In       (Word_Ready_In),
    .Parallel_Data_Out   (Parallel_Data_Out),
    .Load_Data_Signal_Out(Load_Data_Signal_Out),
    .Busy_Out            (Busy_Out),
    .Overrun_Error_Out   (Overrun_Error_Out),
    .Parity_Error_Out    (Parity_Error_Out)
  );

  always #5 Clk_In = ~Clk_In;

  // Downstream PIPO register model.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) pipo_q <= 4'h0;
    else if (Load_Data_Signal_Out) pipo_q <= Parallel_Data_Out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk_In);
    #1;
  endtask

  task automatic send_bit(input logic b);
    Serial_Valid_In = 1'b1;
    Serial_Data_In  = b;
    step();
    Serial_Valid_In = 1'b0;
    Serial_Data_In  = 1'b0;
  endtask

  task automatic start_frame();
    Frame_Start_In = 1'b1;
    step();
    Frame_Start_In = 1'b0;
  endtask

  // Appends the correct even-parity bit in the parity build; no-op otherwise.
  task automatic send_parity(input logic [3:0] w);
`ifdef SERIAL_FRAME_LOADER_PARITY_CHECK_EN
    send_bit(^w);
`else
    if (w === 4'hx) step();
`endif
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] data,
                               input logic load, input logic busy, input logic ovr);
    check({tag, ".data"}, 32'(Parallel_Data_Out), 32'(data));
    check({tag, ".load"}, 32'(Load_Data_Signal_Out), 32'(load));
    check({tag, ".busy"}, 32'(Busy_Out), 32'(busy));
    check({tag, ".ovr"}, 32'(Overrun_Error_Out), 32'(ovr));
  endtask

  initial begin
    Reset_In        = 1'b1;
    Enable_In       = 1'b1;
    Frame_Start_In  = 1'b0;
    Serial_Data_In  = 1'b0;
    Serial_Valid_In = 1'b0;
    Word_Ready_In   = 1'b1;
    step();
    step();
    Reset_In = 1'b0;
    check_outputs("reset0", 4'h0, 1'b0, 1'b0, 1'b0);
    check("reset0.perr", 32'(Parity_Error_Out), 32'd0);

    // Reset mid-frame after two bits.
    start_frame();
    check("start.busy", 32'(Busy_Out), 32'd1);
    send_bit(1'b1);
    send_bit(1'b1);
    Reset_In = 1'b1;
    step();
    step();
    Reset_In = 1'b0;
    check_outputs("midreset", 4'h0, 1'b0, 1'b0, 1'b0);

    // Basic frame 1,0,1,1 -> 0xB with one-cycle load pulse.
    start_frame();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_parity(4'hB);
    check_outputs("basic", 4'hB, 1'b1, 1'b1, 1'b0);
    step();
    check_outputs("basic_acc", 4'hB, 1'b0, 1'b0, 1'b0);
    check("basic.pipo", 32'(pipo_q), 32'hB);

    // Gaps plus three disabled cycles with noisy inputs: 0,1,1,0 -> 0x6.
    start_frame();
    send_bit(1'b0);
    step();
    send_bit(1'b1);
    Enable_In = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Serial_Valid_In = 1'b1;
      Serial_Data_In  = 1'(i);
      Frame_Start_In  = 1'(i == 1);
      step();
      check_outputs("disabled", 4'hB, 1'b0, 1'b1, 1'b0);
    end
    Serial_Valid_In = 1'b0;
    Frame_Start_In  = 1'b0;
    Enable_In       = 1'b1;
    send_bit(1'b1);
    step();
    send_bit(1'b0);
    send_parity(4'h6);
    check_outputs("gaps", 4'h6, 1'b1, 1'b1, 1'b0);
    step();
    check_outputs("gaps_acc", 4'h6, 1'b0, 1'b0, 1'b0);
    check("gaps.pipo", 32'(pipo_q), 32'h6);

    // Backpressure and overrun on word 0x5.
    Word_Ready_In = 1'b0;
    start_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_parity(4'h5);
    check_outputs("bp_hold", 4'h5, 1'b1, 1'b1, 1'b0);
    send_bit(1'b0);
    check_outputs("overrun", 4'h5, 1'b1, 1'b1, 1'b1);
    start_frame();
    check_outputs("hold_ignore_start", 4'h5, 1'b1, 1'b1, 1'b1);
    Word_Ready_In = 1'b1;
    step();
    check_outputs("bp_acc", 4'h5, 1'b0, 1'b0, 1'b1);
    check("bp.pipo", 32'(pipo_q), 32'h5);

    // Restart after three bits, then 0,0,1,1 -> 0x3.
    start_frame();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    start_frame();
    check_outputs("restart_mid", 4'h5, 1'b0, 1'b1, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_parity(4'h3);
    check_outputs("restart", 4'h3, 1'b1, 1'b1, 1'b1);
    step();
    check("restart.pipo", 32'(pipo_q), 32'h3);

`ifdef SERIAL_FRAME_LOADER_PARITY_CHECK_EN
    // Bad parity: 0x7 with parity bit 0.
    start_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check("par_bad.perr", 32'(Parity_Error_Out), 32'd1);
    check_outputs("par_bad", 4'h3, 1'b0, 1'b0, 1'b1);
    step();
    check("par_bad.pulse", 32'(Parity_Error_Out), 32'd0);
    check("par_bad.pipo", 32'(pipo_q), 32'h3);
    // Good parity: 0x7 with parity bit 1.
    start_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("par_ok.perr", 32'(Parity_Error_Out), 32'd0);
    check_outputs("par_ok", 4'h7, 1'b1, 1'b1, 1'b1);
    step();
    check("par_ok.pipo", 32'(pipo_q), 32'h7);
`else
    check("noparity.perr", 32'(Parity_Error_Out), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_loader_4_bit.md
# serial_frame_loader_4_bit

Upstream feeder for the 4-bit parallel-in-parallel-out register stage.
- Assembles a framed serial bitstream into a 4-bit word.
- Presents the word on a parallel bus with a load strobe that drives the PIPO register's load input directly.
- Holds each word until the downstream stage accepts it, and flags overrun when serial data arrives while a word is still pending.

## Interface
Parameters:
- DATA_WIDTH, 4, bits per word; legal range 2..8.
- MSB_FIRST, 1, 1 = first received bit lands in bit DATA_WIDTH-1; 0 = first received bit lands in bit 0.

Ports:
- Clk_In  input  1  single clock; all state updates on rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Enable_In  input  1  1 = block advances; 0 = all state and outputs frozen (Reset_In still wins).
- Frame_Start_In  input  1  arms a new frame.
- Serial_Data_In  input  1  serial bit.
- Serial_Valid_In  input  1  qualifies Serial_Data_In for the current cycle.
- Word_Ready_In  input  1  downstream accepts the pending word.
- Parallel_Data_Out  output  DATA_WIDTH  last completed word.
- Load_Data_Signal_Out  output  1  word pending; connects to the PIPO load input.
- Busy_Out  output  1  high in any state other than IDLE.
- Overrun_Error_Out  output  1  sticky error flag.
- Parity_Error_Out  output  1  one-cycle error pulse (see Configuration).

## Operation
- Reset values: state IDLE, bit counter 0, shift register 0, Parallel_Data_Out 0, and Load_Data_Signal_Out, Busy_Out, Overrun_Error_Out and Parity_Error_Out all 0.
- States: IDLE, SHIFT, PARITY (only when the macro is defined), HOLD.
- IDLE:
  - Frame_Start_In=1 moves to SHIFT and clears the counter.
  - Serial_Valid_In is ignored.
- SHIFT:
  - Each cycle with Serial_Valid_In=1 shifts in one bit and increments the counter.
  - MSB_FIRST=1: reg <= {reg[W-2:0], bit}. MSB_FIRST=0: reg <= {bit, reg[W-1:1]}.
  - Frame_Start_In=1 restarts the frame: partial bits are discarded, the counter is cleared, and that cycle's bit is not captured. Frame_Start_In takes priority over Serial_Valid_In.
  - On the DATA_WIDTH-th valid bit, the state moves to HOLD (or PARITY). On entry to HOLD, Parallel_Data_Out takes the completed word.
- HOLD:
  - Load_Data_Signal_Out=1.
  - Word_Ready_In=1 completes the transfer and returns to IDLE.
  - Serial_Valid_In=1 drops the bit and sets Overrun_Error_Out. Overrun_Error_Out stays set until Reset_In.
  - Frame_Start_In is ignored until the word is accepted.
- Parallel_Data_Out changes only on entry to HOLD. It keeps its value after acceptance.
- Enable_In=0: no state, counter, register or output changes, and all inputs are ignored.
- Reset_In=1 mid-frame or in HOLD returns the block to its reset values on that edge. The pending word is lost.

## Timing
- The DATA_WIDTH-th valid bit is sampled at edge N. At edge N, Parallel_Data_Out and Load_Data_Signal_Out=1 update; both are visible during cycle N+1.
- With Word_Ready_In tied high:
  - Load_Data_Signal_Out is high for exactly one cycle.
  - Minimum frame is 1 (start) + DATA_WIDTH (bits) + 1 (hold) cycles.
- Word_Ready_In sampled high at edge M in HOLD: Load_Data_Signal_Out=0 and IDLE from edge M. A new Frame_Start_In is accepted at edge M+1.
- Busy_Out is registered and equals (state != IDLE).
- Every output is a registered flop output; no combinational input-to-output paths.

## Configuration
- Macro SERIAL_FRAME_LOADER_PARITY_CHECK_EN.
- Defined:
  - After the DATA_WIDTH data bits, the PARITY state waits for one more valid bit (even parity over data plus parity bit).
  - Match: enter HOLD with the word.
  - Mismatch: Parity_Error_Out=1 for one cycle, return to IDLE, Parallel_Data_Out unchanged, no load strobe.
  - Frame_Start_In in PARITY restarts exactly as in SHIFT.
- Undefined: the PARITY state is absent, the transition is SHIFT to HOLD directly, and Parity_Error_Out is constant 0. The port list is identical in both builds.

## Test plan
- Reset: drive Reset_In=1 for 2 cycles mid-frame after 2 bits. All outputs must be 0, state IDLE, and the next frame must assemble correctly.
- Basic frame, MSB_FIRST=1, Word_Ready_In=1: Frame_Start_In, then valid bits 1,0,1,1. Parallel_Data_Out=0xB with a one-cycle Load_Data_Signal_Out pulse; a downstream PIPO model must read 0xB.
- Gaps and enable: bits 0,1,1,0 with Serial_Valid_In low between bits, plus Enable_In=0 for 3 cycles mid-frame. Result must be 0x6; no change during the disabled cycles.
- Backpressure/overrun: Word_Ready_In=0 after word 0x5 completes, then one Serial_Valid_In=1. Overrun_Error_Out=1 and the word stays 0x5. On Word_Ready_In=1, the block returns to IDLE and the flag stays set.
- Restart: send 3 bits, then Frame_Start_In, then bits 0,0,1,1. Result must be 0x3 with the discarded bits having no effect.
- Parity build: data 0x7 with parity bit 1 gives a load of 0x7. Data 0x7 with parity bit 0 gives a Parity_Error_Out pulse, no load, and Parallel_Data_Out keeps its previous value.
